// File: rtl/uart_rx.sv
// UART receiver: oversampled serial input, 2-of-3 majority voting per bit,
// optional even/odd parity, one stop bit. Frame settings are latched at the
// start of each frame so they cannot change mid-frame.
//
// Output pulses are registered. Each one is high for exactly one CLK cycle,
// in the cycle after the edge count Prescale-1 that decided it.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  Parity_EN,
    input  logic                  Parity_type,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_valid,
    output logic                  Parity_error,
    output logic                  Stop_error
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, state_next;
    logic [5:0]            edge_cnt;
    logic [5:0]            presc_q;
    logic [5:0]            mid;
    logic [BW-1:0]         bit_cnt;
    logic                  par_en_q, par_type_q, par_err_q;
    logic [2:0]            samp;
    logic [DATA_WIDTH-1:0] shift_q;

    logic edge_last, bit_last, bit_val, par_exp;
    logic start_frame, dv_next, pe_next, se_next;

    // The edge counter wraps at Prescale-1. An illegal Prescale only changes
    // the wrap point, so every state still times out and the FSM cannot lock up.
    assign mid       = presc_q >> 1;
    assign edge_last = (edge_cnt == presc_q - 6'd1);
    assign bit_last  = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign bit_val   = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    assign par_exp   = (^shift_q) ^ par_type_q;

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and pulse decisions; every decision is made on the last
    // edge of a bit, once all three samples are in.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        dv_next     = 1'b0;
        pe_next     = 1'b0;
        se_next     = 1'b0;
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_next  = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (edge_last) state_next = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (edge_last && bit_last) state_next = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (edge_last) begin
                    state_next = STOP;
                    pe_next    = (bit_val != par_exp);
                end
            end
            STOP: begin
                if (edge_last) begin
                    se_next = !bit_val;
                    dv_next = bit_val && !par_err_q;
                    // A low line here is the next frame's start bit.
                    if (!RX_IN) begin
                        state_next  = START;
                        start_frame = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, sampling, shift register, frame settings and registered outputs
    always_ff @(posedge CLK) begin
        if (Reset) begin
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            presc_q      <= '0;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            par_err_q    <= 1'b0;
            samp         <= '0;
            shift_q      <= '0;
            P_DATA       <= '0;
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            Stop_error   <= 1'b0;
        end else begin
            if (start_frame) begin
                edge_cnt   <= '0;
                bit_cnt    <= '0;
                presc_q    <= Prescale;
                par_en_q   <= Parity_EN;
                par_type_q <= Parity_type;
                par_err_q  <= 1'b0;
                shift_q    <= '0;
            end else if (state != IDLE) begin
                edge_cnt <= edge_last ? 6'd0 : edge_cnt + 6'd1;
                if (state == DATA && edge_last) begin
                    shift_q[bit_cnt] <= bit_val;
                    bit_cnt          <= bit_last ? '0 : bit_cnt + 1'b1;
                end
            end

            if (state != IDLE) begin
                if (edge_cnt == mid - 6'd1) samp[0] <= RX_IN;
                if (edge_cnt == mid)        samp[1] <= RX_IN;
                if (edge_cnt == mid + 6'd1) samp[2] <= RX_IN;
            end

            if (pe_next) par_err_q <= 1'b1;

            Data_valid   <= dv_next;
            Parity_error <= pe_next;
            Stop_error   <= se_next;
            if (dv_next) P_DATA <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a table of single frames with hand-computed results,
// followed by hand-written glitch, back-to-back and mid-frame reset sequences.
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       rx_in;
    logic [5:0] prescale;
    logic       parity_en;
    logic       parity_type;
    logic [7:0] p_data;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
    int dv_last_cyc = 0, dv_prev_cyc = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK          (clk),
        .Reset        (reset),
        .RX_IN        (rx_in),
        .Prescale     (prescale),
        .Parity_EN    (parity_en),
        .Parity_type  (parity_type),
        .P_DATA       (p_data),
        .Data_valid   (data_valid),
        .Parity_error (parity_error),
        .Stop_error   (stop_error)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard: counts pulses and compares each received word to the queue
    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt++;
            dv_prev_cyc = dv_last_cyc;
            dv_last_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_data_valid", 1, 0);
            end else begin
                check("p_data_on_valid", int'(p_data), int'(exp_q.pop_front()));
            end
        end
        if (parity_error) pe_cnt++;
        if (stop_error)   se_cnt++;
    end

    // Drivers
    task automatic drive_bit(input logic b, input int n);
        rx_in = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [5:0] presc, input logic [7:0] data,
                              input logic pen, input logic pbit, input logic sbit);
        drive_bit(1'b0, int'(presc));
        for (int i = 0; i < 8; i++) drive_bit(data[i], int'(presc));
        if (pen) drive_bit(pbit, int'(presc));
        drive_bit(sbit, int'(presc));
    endtask

    typedef struct {
        logic [5:0] presc;
        logic       par_en;
        logic       par_type;
        logic [7:0] data;
        logic       par_bit;
        logic       stop_bit;
        int         exp_dv;
        int         exp_pe;
        int         exp_se;
        logic [7:0] exp_pdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int d0, p0, s0, c0;

        vecs[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
        vecs[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1, 0, 0, 8'h3C};
        vecs[2] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 0, 1, 0, 8'h3C};
        vecs[3] = '{6'd32, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0, 0, 1, 8'h3C};
        vecs[4] = '{6'd8,  1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1, 0, 0, 8'h5A};
        vecs[5] = '{6'd32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF};
        vecs[6] = '{6'd16, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 0, 1, 1, 8'hFF};

        // Reset
        reset = 1'b1; rx_in = 1'b1; prescale = 6'd8; parity_en = 1'b0; parity_type = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_p_data", int'(p_data), 0);
        check("reset_data_valid", int'(data_valid), 0);
        check("reset_parity_error", int'(parity_error), 0);
        check("reset_stop_error", int'(stop_error), 0);
        reset = 1'b0;
        drive_bit(1'b1, 5);

        // Table-driven single frames
        for (int v = 0; v < 7; v++) begin
            prescale = vecs[v].presc; parity_en = vecs[v].par_en; parity_type = vecs[v].par_type;
            if (vecs[v].exp_dv != 0) exp_q.push_back(vecs[v].data);
            d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt; c0 = cyc;
            send_frame(vecs[v].presc, vecs[v].data, vecs[v].par_en, vecs[v].par_bit, vecs[v].stop_bit);
            drive_bit(1'b1, 2 * int'(vecs[v].presc));
            check($sformatf("vec%0d_dv_count", v), dv_cnt - d0, vecs[v].exp_dv);
            check($sformatf("vec%0d_pe_count", v), pe_cnt - p0, vecs[v].exp_pe);
            check($sformatf("vec%0d_se_count", v), se_cnt - s0, vecs[v].exp_se);
            check($sformatf("vec%0d_p_data", v), int'(p_data), int'(vecs[v].exp_pdata));
            if (vecs[v].exp_dv != 0)
                check($sformatf("vec%0d_latency", v), dv_last_cyc - c0,
                      (10 + int'(vecs[v].par_en)) * int'(vecs[v].presc) + 1);
        end

        // Start-bit glitch at Prescale=16, then a good frame
        prescale = 6'd16; parity_en = 1'b0;
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 40);
        check("glitch_pulses", (dv_cnt - d0) + (pe_cnt - p0) + (se_cnt - s0), 0);
        check("glitch_p_data_held", int'(p_data), 8'hFF);
        exp_q.push_back(8'h81);
        d0 = dv_cnt;
        send_frame(6'd16, 8'h81, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 32);
        check("after_glitch_dv", dv_cnt - d0, 1);
        check("after_glitch_p_data", int'(p_data), 8'h81);

        // Back-to-back frames at Prescale=8
        prescale = 6'd8;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        d0 = dv_cnt;
        send_frame(6'd8, 8'h12, 1'b0, 1'b0, 1'b1);
        send_frame(6'd8, 8'h34, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 16);
        check("b2b_dv_count", dv_cnt - d0, 2);
        check("b2b_spacing", dv_last_cyc - dv_prev_cyc, 80);
        check("b2b_p_data", int'(p_data), 8'h34);

        // Reset during bit 4 of 0xFF, then a good frame
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
        drive_bit(1'b1, 3);
        reset = 1'b1;
        drive_bit(1'b1, 2);
        reset = 1'b0;
        drive_bit(1'b1, 24);
        check("midreset_pulses", (dv_cnt - d0) + (pe_cnt - p0) + (se_cnt - s0), 0);
        check("midreset_p_data", int'(p_data), 0);
        exp_q.push_back(8'h55);
        d0 = dv_cnt;
        send_frame(6'd8, 8'h55, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 16);
        check("after_reset_dv", dv_cnt - d0, 1);
        check("after_reset_p_data", int'(p_data), 8'h55);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
